regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised successor to the pipeline register file. It provides a configurable number of combinational read ports, one write port committed on the rising clock edge, and register 0 hardwired to zero. A per-register pending-write scoreboard lets the decode stage detect RAW hazards against in-flight producers. It sits between decode (reads, destination allocation) and write-back (commit).

## Interface
- DATA_WIDTH, 32, width of each register
- REG_NUM, 32, number of architectural registers; power of two, ≥ 2
- READ_PORTS, 2, number of independent read ports; ≥ 1
- AW (localparam), $clog2(REG_NUM), register address width
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all registers and the scoreboard
- readAddr  input  READ_PORTS*AW  flattened read addresses; port k uses bits [k*AW +: AW]
- readData  output  READ_PORTS*DATA_WIDTH  flattened read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- readBusy  output  READ_PORTS  port k's register has a pending write not yet committed
- writeEnable  input  1  commit writeData to writeAddr on the next rising edge
- writeAddr  input  AW  write-back destination
- writeData  input  DATA_WIDTH  write-back value
- allocEnable  input  1  mark allocAddr pending on the next rising edge
- allocAddr  input  AW  destination of the instruction being issued
- pendingCount  output  $clog2(REG_NUM)+1  number of registers currently pending

## Operation
- Storage: REG_NUM x DATA_WIDTH flops. Register 0 is never written and always reads 0.
- Write: on the rising edge, if writeEnable && writeAddr != 0, then MEM[writeAddr] <= writeData and pending[writeAddr] <= 0.
- Alloc: on the rising edge, if allocEnable && allocAddr != 0, then pending[allocAddr] <= 1.
- Alloc and write to the same address in the same cycle: alloc wins and pending stays 1, because a newer producer has been issued. The data write still commits.
- Alloc to an address that is already pending: no change. The scoreboard does not count multiple producers.
- Write to a register that is not pending: the data commits and pending stays 0.
- Read (combinational), per port: readData = MEM[readAddr], subject to the bypass rule in Configuration. Address 0 returns 0.
- readBusy per port = pending[readAddr], with the bypass exception in Configuration. Address 0 is never busy.
- pendingCount is a registered counter updated every edge by (+1 if alloc sets a bit that was clear) and (−1 if write clears a bit that was set, and no alloc targets the same address). The same-address alloc+write case yields net 0.
- pendingCount never exceeds REG_NUM−1 and never underflows. pendingCount must always equal the popcount of pending.

## Timing
- Reset (asynchronous assertion, synchronous-safe release): all MEM = 0, pending = 0, pendingCount = 0. While reset is high, all readData = 0 and all readBusy = 0.
- Reset asserted mid-operation discards all in-flight allocs and writes. The first edge after deassertion behaves normally.
- Write latency: data is visible on the read path in the cycle after the commit edge. It is visible in the same cycle only with the bypass compiled in.
- Alloc latency: readBusy rises in the cycle after the alloc edge.
- Read ports have zero latency, with no ordering between ports. Every port may read the same address.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When writeEnable && writeAddr == readAddr[k] && writeAddr != 0, port k returns writeData in the same cycle.
  - readBusy[k] = 0 for that port, unless allocEnable targets the same address in that cycle. In that case readBusy[k] stays pending[readAddr[k]].
- REGFILE_BYPASS_EN undefined:
  - Reads always return stored MEM contents.
  - readBusy reflects registered pending only.
  - Decode must stall one extra cycle on a write-back collision.

## Test plan
- Reset check: hold reset for 2 cycles after writing 0xDEADBEEF to r5. Required: readData for r5 = 0, readBusy = 0, pendingCount = 0.
- Zero register: write 0x12345678 to r0 and alloc r0. Required: r0 reads 0, readBusy = 0, pendingCount = 0.
- Scoreboard flow:
  - Alloc r7 at cycle 0. Required: readBusy = 1 from cycle 1, pendingCount = 1.
  - Write 0xA5A5A5A5 to r7 at cycle 3. Required: cycle 4 reads 0xA5A5A5A5, busy = 0, pendingCount = 0.
- Same-cycle write and read of r9 = 0x55:
  - With REGFILE_BYPASS_EN: 0x55 in the same cycle.
  - Without it: the old value that cycle and 0x55 the next cycle.
- Same-cycle alloc+write to r3 while r3 is pending: the write data commits, r3 stays busy, and pendingCount is unchanged.
- Fill: alloc r1..r31 on consecutive cycles. Required: pendingCount = 31. Then write all 31 registers. Required: pendingCount = 0 and every port reads the written values.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back bus of the register file scoreboard: read ports, commit port,
// destination allocation and the pending-register count.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int READ_PORTS = 2
);
  localparam int AW = $clog2(REG_NUM);

  logic [READ_PORTS*AW-1:0]         readAddr;
  logic [READ_PORTS*DATA_WIDTH-1:0] readData;
  logic [READ_PORTS-1:0]            readBusy;
  logic                             writeEnable;
  logic [AW-1:0]                    writeAddr;
  logic [DATA_WIDTH-1:0]            writeData;
  logic                             allocEnable;
  logic [AW-1:0]                    allocAddr;
  logic [AW:0]                      pendingCount;

  modport master (
    output readAddr, writeEnable, writeAddr, writeData, allocEnable, allocAddr,
    input  readData, readBusy, pendingCount
  );

  modport slave (
    input  readAddr, writeEnable, writeAddr, writeData, allocEnable, allocAddr,
    output readData, readBusy, pendingCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with r0 hardwired to zero and a per-register pending-write
// scoreboard. Optional same-cycle write-to-read bypass is enabled by REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int READ_PORTS = 2
) (
  input logic                clk,
  input logic                reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(REG_NUM);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [REG_NUM];
  logic [REG_NUM-1:0]    pending;
  logic [CW-1:0]         pend_count;
  logic [CW-1:0]         next_count;
  logic                  wr_ok;
  logic                  al_ok;
  logic                  cnt_inc;
  logic                  cnt_dec;
  logic [AW-1:0]         rd_addr [READ_PORTS];

  assign wr_ok = bus.writeEnable && (bus.writeAddr != '0);
  assign al_ok = bus.allocEnable && (bus.allocAddr != '0);

  // A same-address alloc keeps the bit set, so the write must not decrement the count.
  always_comb begin
    cnt_inc    = al_ok && !pending[bus.allocAddr];
    cnt_dec    = wr_ok && pending[bus.writeAddr] &&
                 !(al_ok && (bus.allocAddr == bus.writeAddr));
    next_count = pend_count + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.writeAddr] <= bus.writeData;
    end
  end

  // Alloc is applied after the write clear so a newer producer wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      pend_count <= '0;
    end else begin
      if (wr_ok) begin
        pending[bus.writeAddr] <= 1'b0;
      end
      if (al_ok) begin
        pending[bus.allocAddr] <= 1'b1;
      end
      pend_count <= next_count;
    end
  end

  assign bus.pendingCount = pend_count;

  always_comb begin
    for (int k = 0; k < READ_PORTS; k++) begin
      rd_addr[k] = bus.readAddr[k*AW +: AW];
    end
  end

  always_comb begin
    bus.readData = '0;
    bus.readBusy = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      bus.readData[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[k]];
      bus.readBusy[k]                          = pending[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.writeAddr == rd_addr[k])) begin
        bus.readData[k*DATA_WIDTH +: DATA_WIDTH] = bus.writeData;
        if (!(al_ok && (bus.allocAddr == rd_addr[k]))) begin
          bus.readBusy[k] = 1'b0;
        end
      end
`endif
      if (reset || (rd_addr[k] == '0)) begin
        bus.readData[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        bus.readBusy[k]                          = 1'b0;
      end
    end
  end
endmodule
